// File: rtl/wbdbgbus_fwft_fifo_if.sv
// Push/pop/status bundle for the debug-bus FWFT FIFO.
// The FIFO takes the slave view; the producer/consumer side takes the master view.
interface wbdbgbus_fwft_fifo_if #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 128
);
  localparam int AW = $clog2(DEPTH);

  logic             i_wr_en;
  logic [WIDTH-1:0] i_wr_data;
  logic             i_rd_en;
  logic             i_clr_err;
  logic [WIDTH-1:0] o_rd_data;
  logic             o_rd_valid;
  logic             o_empty;
  logic             o_full;
  logic             o_almost_full;
  logic             o_almost_empty;
  logic [AW:0]      o_level;
  logic             o_overflow;
  logic             o_underflow;

  modport slave (
    input  i_wr_en, i_wr_data, i_rd_en, i_clr_err,
    output o_rd_data, o_rd_valid, o_empty, o_full, o_almost_full,
           o_almost_empty, o_level, o_overflow, o_underflow
  );

  modport master (
    output i_wr_en, i_wr_data, i_rd_en, i_clr_err,
    input  o_rd_data, o_rd_valid, o_empty, o_full, o_almost_full,
           o_almost_empty, o_level, o_overflow, o_underflow
  );
endinterface

// File: rtl/wbdbgbus_fwft_fifo.sv
// First-word-fall-through FIFO: a head register with valid bit backed by a DEPTH-entry RAM,
// with occupancy count, almost-full/empty thresholds and sticky overflow/underflow flags.
module wbdbgbus_fwft_fifo #(
  parameter int WIDTH         = 36,
  parameter int DEPTH         = 128,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst,
  wbdbgbus_fwft_fifo_if.slave                           bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_AFULL  = (AW+1)'(AFULL_THRESH);
  localparam logic [AW:0] LVL_AEMPTY = (AW+1)'(AEMPTY_THRESH);
  localparam logic [AW:0] CNT_ZERO   = {(AW+1){1'b0}};
  localparam logic [AW:0] CNT_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_head;
  logic             r_head_valid;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_ram_cnt;
  logic [AW:0]      r_level;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_ram_has;
  logic w_ram_rd;
  logic w_ram_wr;
  logic w_bypass;
  logic w_ovf_evt;
  logic w_unf_evt;

  assign w_full    = (r_level == LVL_FULL);
  assign w_pop     = bus.i_rd_en & r_head_valid;
  assign w_push    = bus.i_wr_en & (~w_full | w_pop);
  assign w_ram_has = (r_ram_cnt != CNT_ZERO);
  // The bypass into the head is only taken while the RAM is empty, which preserves FIFO order.
  assign w_ram_rd  = w_pop & w_ram_has;
  assign w_ram_wr  = w_push & (w_pop ? w_ram_has : r_head_valid);
  assign w_bypass  = w_push & ~w_ram_has & (w_pop | ~r_head_valid);
  assign w_ovf_evt = bus.i_wr_en & w_full & ~w_pop;
  assign w_unf_evt = bus.i_rd_en & ~r_head_valid;

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_ram_wr) begin
      r_mem[r_wr_ptr] <= bus.i_wr_data;
    end
  end

  // Head register, pointers, counts and sticky error flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head       <= {WIDTH{1'b0}};
      r_head_valid <= 1'b0;
      r_wr_ptr     <= {AW{1'b0}};
      r_rd_ptr     <= {AW{1'b0}};
      r_ram_cnt    <= CNT_ZERO;
      r_level      <= CNT_ZERO;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_ram_rd) begin
        r_head   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else if (w_bypass) begin
        r_head       <= bus.i_wr_data;
        r_head_valid <= 1'b1;
      end else if (w_pop) begin
        r_head_valid <= 1'b0;
      end

      if (w_ram_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end

      case ({w_ram_wr, w_ram_rd})
        2'b10:   r_ram_cnt <= r_ram_cnt + CNT_ONE;
        2'b01:   r_ram_cnt <= r_ram_cnt - CNT_ONE;
        default: r_ram_cnt <= r_ram_cnt;
      endcase

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + CNT_ONE;
        2'b01:   r_level <= r_level - CNT_ONE;
        default: r_level <= r_level;
      endcase

      // A new error event in the clearing cycle wins over the clear.
      if (bus.i_clr_err) begin
        r_overflow  <= w_ovf_evt;
        r_underflow <= w_unf_evt;
      end else begin
        r_overflow  <= r_overflow | w_ovf_evt;
        r_underflow <= r_underflow | w_unf_evt;
      end
    end
  end

  assign bus.o_rd_data      = r_head;
  assign bus.o_rd_valid     = r_head_valid;
  assign bus.o_empty        = (r_level == CNT_ZERO);
  assign bus.o_full         = w_full;
  assign bus.o_almost_full  = (r_level >= LVL_AFULL);
  assign bus.o_almost_empty = (r_level <= LVL_AEMPTY);
  assign bus.o_level        = r_level;
  assign bus.o_overflow     = r_overflow;
  assign bus.o_underflow    = r_underflow;
endmodule

// File: tb/tb_wbdbgbus_fwft_fifo.sv
// Directed bench for wbdbgbus_fwft_fifo at DEPTH=8, thresholds 6/2, 8-bit words.
module tb_wbdbgbus_fwft_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   err_cnt = 0;
  int   chk_cnt = 0;

  wbdbgbus_fwft_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  wbdbgbus_fwft_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(6), .AEMPTY_THRESH(2)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    bus.i_wr_en   = 1'b0;
    bus.i_rd_en   = 1'b0;
    bus.i_clr_err = 1'b0;
  endtask

  initial begin
    idle();
    bus.i_wr_data = 8'h00;
    step();
    step();
    check("rst_empty", 32'(bus.o_empty), 32'd1);
    check("rst_level", 32'(bus.o_level), 32'd0);
    check("rst_valid", 32'(bus.o_rd_valid), 32'd0);
    check("rst_full", 32'(bus.o_full), 32'd0);
    check("rst_aempty", 32'(bus.o_almost_empty), 32'd1);
    check("rst_afull", 32'(bus.o_almost_full), 32'd0);
    check("rst_ovf", 32'(bus.o_overflow), 32'd0);
    check("rst_unf", 32'(bus.o_underflow), 32'd0);
    i_rst = 1'b0;

    // Bypass push into empty FIFO
    bus.i_wr_en = 1'b1; bus.i_wr_data = 8'hA5;
    step();
    idle();
    check("byp_valid", 32'(bus.o_rd_valid), 32'd1);
    check("byp_data", 32'(bus.o_rd_data), 32'hA5);
    check("byp_level", 32'(bus.o_level), 32'd1);
    bus.i_rd_en = 1'b1;
    step();
    idle();
    check("byp_drain", 32'(bus.o_empty), 32'd1);

    // Fill 0..7 with threshold tracking
    for (int i = 0; i < 8; i++) begin
      bus.i_wr_en = 1'b1; bus.i_wr_data = 8'(i);
      step();
      check("fill_level", 32'(bus.o_level), 32'(i + 1));
      check("fill_afull", 32'(bus.o_almost_full), ((i + 1) >= 6) ? 32'd1 : 32'd0);
      check("fill_full", 32'(bus.o_full), ((i + 1) == 8) ? 32'd1 : 32'd0);
      check("fill_aempty", 32'(bus.o_almost_empty), ((i + 1) <= 2) ? 32'd1 : 32'd0);
      check("fill_head", 32'(bus.o_rd_data), 32'd0);
    end
    bus.i_wr_data = 8'h99;
    step();
    idle();
    check("ovf_level", 32'(bus.o_level), 32'd8);
    check("ovf_flag", 32'(bus.o_overflow), 32'd1);
    check("ovf_head", 32'(bus.o_rd_data), 32'd0);
    bus.i_clr_err = 1'b1;
    step();
    idle();
    check("ovf_clr", 32'(bus.o_overflow), 32'd0);

    // Drain 0..7 in order
    for (int i = 0; i < 8; i++) begin
      check("drain_data", 32'(bus.o_rd_data), 32'(i));
      bus.i_rd_en = 1'b1;
      step();
    end
    idle();
    check("drain_empty", 32'(bus.o_empty), 32'd1);
    check("drain_level", 32'(bus.o_level), 32'd0);

    // Refill, then push+pop at full across pointer wrap
    for (int i = 0; i < 8; i++) begin
      bus.i_wr_en = 1'b1; bus.i_wr_data = 8'(i);
      step();
    end
    check("refill_full", 32'(bus.o_full), 32'd1);
    for (int i = 0; i < 20; i++) begin
      check("fullpp_data", 32'(bus.o_rd_data), 32'(i));
      bus.i_wr_en = 1'b1; bus.i_rd_en = 1'b1; bus.i_wr_data = 8'(i + 8);
      step();
      check("fullpp_level", 32'(bus.o_level), 32'd8);
      check("fullpp_ovf", 32'(bus.o_overflow), 32'd0);
    end
    idle();
    for (int i = 20; i < 28; i++) begin
      check("wrap_data", 32'(bus.o_rd_data), 32'(i));
      bus.i_rd_en = 1'b1;
      step();
    end
    idle();
    check("wrap_empty", 32'(bus.o_empty), 32'd1);

    // Streaming through an empty FIFO
    bus.i_wr_en = 1'b1; bus.i_wr_data = 8'h10;
    step();
    check("strm_level0", 32'(bus.o_level), 32'd1);
    for (int k = 1; k < 16; k++) begin
      check("strm_data", 32'(bus.o_rd_data), 32'(8'h10 + k - 1));
      bus.i_wr_en = 1'b1; bus.i_rd_en = 1'b1; bus.i_wr_data = 8'(8'h10 + k);
      step();
      check("strm_level", 32'(bus.o_level), 32'd1);
    end
    idle();
    check("strm_last", 32'(bus.o_rd_data), 32'h1F);
    bus.i_rd_en = 1'b1;
    step();
    idle();
    check("strm_end_level", 32'(bus.o_level), 32'd0);
    check("strm_unf", 32'(bus.o_underflow), 32'd0);

    // Underflow, set-wins clear, plain clear
    bus.i_rd_en = 1'b1;
    step();
    idle();
    check("unf_flag", 32'(bus.o_underflow), 32'd1);
    check("unf_level", 32'(bus.o_level), 32'd0);
    bus.i_rd_en = 1'b1; bus.i_clr_err = 1'b1;
    step();
    idle();
    check("unf_setwins", 32'(bus.o_underflow), 32'd1);
    bus.i_clr_err = 1'b1;
    step();
    idle();
    check("unf_clr", 32'(bus.o_underflow), 32'd0);

    // Reset mid-operation at level 5 with a pending underflow flag
    bus.i_rd_en = 1'b1;
    step();
    idle();
    for (int i = 0; i < 5; i++) begin
      bus.i_wr_en = 1'b1; bus.i_wr_data = 8'(8'h30 + i);
      step();
    end
    idle();
    check("mid_level5", 32'(bus.o_level), 32'd5);
    check("mid_unf_pre", 32'(bus.o_underflow), 32'd1);
    i_rst = 1'b1;
    bus.i_wr_en = 1'b1; bus.i_rd_en = 1'b1; bus.i_wr_data = 8'hEE;
    step();
    i_rst = 1'b0;
    idle();
    check("mid_level", 32'(bus.o_level), 32'd0);
    check("mid_empty", 32'(bus.o_empty), 32'd1);
    check("mid_valid", 32'(bus.o_rd_valid), 32'd0);
    check("mid_ovf", 32'(bus.o_overflow), 32'd0);
    check("mid_unf", 32'(bus.o_underflow), 32'd0);
    bus.i_wr_en = 1'b1; bus.i_wr_data = 8'h77;
    step();
    idle();
    check("fresh_data", 32'(bus.o_rd_data), 32'h77);
    check("fresh_level", 32'(bus.o_level), 32'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
